// File: rtl/processor_pkg.sv
// processor_pkg
// Command encoding shared by the fetch-path PC and the control unit.
//   cmd_t                 3-bit command select
//   CMD_HOLD .. CMD_CALL  command codes, numerically ordered by priority
//   priority_encode()     picks one command from the individual strobes
package processor_pkg;

    typedef logic [2:0] cmd_t;

    localparam cmd_t CMD_HOLD   = 3'd0;
    localparam cmd_t CMD_INC    = 3'd1;
    localparam cmd_t CMD_BRANCH = 3'd2;
    localparam cmd_t CMD_LOAD   = 3'd3;
    localparam cmd_t CMD_RETURN = 3'd4;
    localparam cmd_t CMD_CALL   = 3'd5;

    // CALL > RETURN > LOAD > BRANCH > INCREMENT > hold
    function automatic cmd_t priority_encode(
        input logic call,
        input logic ret,
        input logic load,
        input logic branch,
        input logic inc
    );
        if (call)        return CMD_CALL;
        else if (ret)    return CMD_RETURN;
        else if (load)   return CMD_LOAD;
        else if (branch) return CMD_BRANCH;
        else if (inc)    return CMD_INC;
        else             return CMD_HOLD;
    endfunction

endpackage

// File: rtl/return_stack.sv
// return_stack
// LIFO of return addresses for CALL/RETURN.
//   CLOCK, RESET_N   clock, async active-low reset (clears depth and entries)
//   push, push_data  write push_data on top (ignored when full)
//   pop              discard top entry (ignored when empty)
//   top_data         entry at depth-1 (meaningless when empty)
//   depth            entries in use, 0..DEPTH
//   full, empty      occupancy status
module return_stack
    import processor_pkg::*;
#(
    parameter int BITS  = 16,
    parameter int DEPTH = 4
) (
    input  logic                       CLOCK,
    input  logic                       RESET_N,
    input  logic                       push,
    input  logic                       pop,
    input  logic [BITS-1:0]            push_data,
    output logic [BITS-1:0]            top_data,
    output logic [$clog2(DEPTH):0]     depth,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_COUNT  = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_PTR  = AW'(1);

    logic [BITS-1:0] entries [DEPTH];
    logic [AW:0]     depth_q;
    logic [AW-1:0]   top_ptr;

    // DEPTH is a power of two, so the low AW bits minus one wrap to DEPTH-1
    // when the stack is full, which is exactly the top slot.
    assign top_ptr  = depth_q[AW-1:0] - ONE_PTR;
    assign top_data = entries[top_ptr];
    assign depth    = depth_q;
    assign full     = (depth_q == FULL_COUNT);
    assign empty    = (depth_q == '0);

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            depth_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (push && !full) begin
            entries[depth_q[AW-1:0]] <= push_data;
            depth_q                  <= depth_q + ONE_COUNT;
        end else if (pop && !empty) begin
            depth_q <= depth_q - ONE_COUNT;
        end
    end

endmodule

// File: rtl/program_counter_stack.sv
// program_counter_stack
// Fetch-path program counter with load, increment, relative branch and a
// hardware return-address stack.
// Build option: PC_SATURATE_EN -- when defined, INCREMENT and BRANCH clamp at
// 0 / all-ones instead of wrapping (the pushed return address still wraps).
//   CLOCK, RESET_N        clock, async active-low reset
//   LOAD/INCREMENT/BRANCH/CALL/RETURN   command strobes, fixed priority
//   CLEAR_FLAGS           clears sticky OVERFLOW/UNDERFLOW
//   DATA                  absolute target for LOAD/CALL
//   OFFSET                two's-complement displacement for BRANCH
//   OUT                   current fetch address
//   STACK_DEPTH           return-stack entries in use
//   OVERFLOW, UNDERFLOW   sticky stack error flags
module program_counter_stack
    import processor_pkg::*;
#(
    parameter int              BITS        = 16,
    parameter int              DEPTH       = 4,
    parameter logic [BITS-1:0] RESET_VALUE = '0
) (
    input  logic                    CLOCK,
    input  logic                    RESET_N,
    input  logic                    LOAD,
    input  logic                    INCREMENT,
    input  logic                    BRANCH,
    input  logic                    CALL,
    input  logic                    RETURN,
    input  logic                    CLEAR_FLAGS,
    input  logic [BITS-1:0]         DATA,
    input  logic [BITS-1:0]         OFFSET,
    output logic [BITS-1:0]         OUT,
    output logic [$clog2(DEPTH):0]  STACK_DEPTH,
    output logic                    OVERFLOW,
    output logic                    UNDERFLOW
);

    localparam logic [BITS-1:0] ONE = BITS'(1);

    cmd_t            cmd;
    logic [BITS-1:0] pc_q;
    logic [BITS-1:0] pc_next;
    logic [BITS-1:0] pc_plus1;
    logic [BITS-1:0] pc_inc;
    logic [BITS-1:0] pc_branch;
    logic [BITS-1:0] stack_top;
    logic            stack_full;
    logic            stack_empty;
    logic            push;
    logic            pop;
    logic            overflow_q;
    logic            underflow_q;
    logic            overflow_set;
    logic            underflow_set;

    assign cmd      = priority_encode(CALL, RETURN, LOAD, BRANCH, INCREMENT);
    assign pc_plus1 = pc_q + ONE;

`ifdef PC_SATURATE_EN
    // Two guard bits: bit BITS+1 flags a negative result, bit BITS a carry
    // past all-ones.
    logic signed [BITS+1:0] branch_wide;

    assign branch_wide = $signed({2'b00, pc_q}) + $signed({{2{OFFSET[BITS-1]}}, OFFSET});
    assign pc_inc      = (&pc_q) ? pc_q : pc_plus1;

    always_comb begin
        pc_branch = branch_wide[BITS-1:0];
        if (branch_wide[BITS+1]) begin
            pc_branch = '0;
        end else if (branch_wide[BITS]) begin
            pc_branch = '1;
        end
    end
`else
    assign pc_inc    = pc_plus1;
    assign pc_branch = pc_q + OFFSET;
`endif

    always_comb begin
        pc_next       = pc_q;
        push          = 1'b0;
        pop           = 1'b0;
        overflow_set  = 1'b0;
        underflow_set = 1'b0;
        case (cmd)
            CMD_CALL: begin
                if (stack_full) begin
                    overflow_set = 1'b1;
                end else begin
                    push    = 1'b1;
                    pc_next = DATA;
                end
            end
            CMD_RETURN: begin
                if (stack_empty) begin
                    underflow_set = 1'b1;
                end else begin
                    pop     = 1'b1;
                    pc_next = stack_top;
                end
            end
            CMD_LOAD:   pc_next = DATA;
            CMD_BRANCH: pc_next = pc_branch;
            CMD_INC:    pc_next = pc_inc;
            default:    pc_next = pc_q;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc_q        <= RESET_VALUE;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_next;
            // A new error in the clearing cycle keeps the flag set.
            overflow_q  <= overflow_set  | (overflow_q  & ~CLEAR_FLAGS);
            underflow_q <= underflow_set | (underflow_q & ~CLEAR_FLAGS);
        end
    end

    return_stack #(
        .BITS  (BITS),
        .DEPTH (DEPTH)
    ) u_return_stack (
        .CLOCK     (CLOCK),
        .RESET_N   (RESET_N),
        .push      (push),
        .pop       (pop),
        .push_data (pc_plus1),
        .top_data  (stack_top),
        .depth     (STACK_DEPTH),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    assign OUT       = pc_q;
    assign OVERFLOW  = overflow_q;
    assign UNDERFLOW = underflow_q;

endmodule

// File: tb/tb_program_counter_stack.sv
// tb_program_counter_stack
// Directed checks of program_counter_stack with BITS=10, DEPTH=4.
module tb_program_counter_stack;

    localparam int BITS  = 10;
    localparam int DEPTH = 4;

    logic            CLOCK = 1'b0;
    logic            RESET_N = 1'b0;
    logic            LOAD = 1'b0;
    logic            INCREMENT = 1'b0;
    logic            BRANCH = 1'b0;
    logic            CALL = 1'b0;
    logic            RETURN = 1'b0;
    logic            CLEAR_FLAGS = 1'b0;
    logic [BITS-1:0] DATA = '0;
    logic [BITS-1:0] OFFSET = '0;
    logic [BITS-1:0] OUT;
    logic [2:0]      STACK_DEPTH;
    logic            OVERFLOW;
    logic            UNDERFLOW;

    int tests = 0;
    int errors = 0;

    program_counter_stack #(
        .BITS        (BITS),
        .DEPTH       (DEPTH),
        .RESET_VALUE (10'h000)
    ) dut (
        .CLOCK       (CLOCK),
        .RESET_N     (RESET_N),
        .LOAD        (LOAD),
        .INCREMENT   (INCREMENT),
        .BRANCH      (BRANCH),
        .CALL        (CALL),
        .RETURN      (RETURN),
        .CLEAR_FLAGS (CLEAR_FLAGS),
        .DATA        (DATA),
        .OFFSET      (OFFSET),
        .OUT         (OUT),
        .STACK_DEPTH (STACK_DEPTH),
        .OVERFLOW    (OVERFLOW),
        .UNDERFLOW   (UNDERFLOW)
    );

    always #5 CLOCK = ~CLOCK;

    // Advance one posedge, sample 1 time unit later, then drop all strobes.
    task automatic step();
        @(posedge CLOCK);
        #1;
        LOAD = 0; INCREMENT = 0; BRANCH = 0; CALL = 0; RETURN = 0; CLEAR_FLAGS = 0;
    endtask

    task automatic do_load(input logic [BITS-1:0] d);
        LOAD = 1; DATA = d;
        step();
    endtask

    task automatic test_reset();
        RESET_N = 0;
        #12;
        tests++; if (OUT !== 10'h000) begin errors++; $display("FAIL reset_out: got %h expected %h", OUT, 10'h000); end
        tests++; if (STACK_DEPTH !== 3'd0) begin errors++; $display("FAIL reset_depth: got %0d expected 0", STACK_DEPTH); end
        tests++; if ({OVERFLOW, UNDERFLOW} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {OVERFLOW, UNDERFLOW}); end
        @(negedge CLOCK);
        RESET_N = 1;
        // Build OUT=0x155 with depth 2 and an underflow flag pending? no: raise underflow first.
        RETURN = 1; step();
        CALL = 1; DATA = 10'h010; step();
        CALL = 1; DATA = 10'h155; step();
        tests++; if (OUT !== 10'h155 || STACK_DEPTH !== 3'd2 || UNDERFLOW !== 1'b1) begin
            errors++; $display("FAIL pre_reset_state: got out=%h depth=%0d unf=%b expected out=155 depth=2 unf=1", OUT, STACK_DEPTH, UNDERFLOW);
        end
        #2;
        RESET_N = 0;
        #1;
        tests++; if (OUT !== 10'h000) begin errors++; $display("FAIL async_reset_out: got %h expected %h", OUT, 10'h000); end
        tests++; if (STACK_DEPTH !== 3'd0) begin errors++; $display("FAIL async_reset_depth: got %0d expected 0", STACK_DEPTH); end
        tests++; if ({OVERFLOW, UNDERFLOW} !== 2'b00) begin errors++; $display("FAIL async_reset_flags: got %b expected 00", {OVERFLOW, UNDERFLOW}); end
        @(negedge CLOCK);
        RESET_N = 1;
    endtask

    task automatic test_load_inc();
        do_load(10'd15);
        tests++; if (OUT !== 10'd15) begin errors++; $display("FAIL load: got %0d expected 15", OUT); end
        INCREMENT = 1; step();
        tests++; if (OUT !== 10'd16) begin errors++; $display("FAIL inc1: got %0d expected 16", OUT); end
        INCREMENT = 1; step();
        tests++; if (OUT !== 10'd17) begin errors++; $display("FAIL inc2: got %0d expected 17", OUT); end
        LOAD = 1; INCREMENT = 1; DATA = 10'd23; step();
        tests++; if (OUT !== 10'd23) begin errors++; $display("FAIL load_over_inc: got %0d expected 23", OUT); end
        step();
        tests++; if (OUT !== 10'd23) begin errors++; $display("FAIL hold: got %0d expected 23", OUT); end
    endtask

    task automatic test_wrap();
        logic [BITS-1:0] exp_inc, exp_neg, exp_pos;
`ifdef PC_SATURATE_EN
        exp_inc = 10'h3FF; exp_neg = 10'h000; exp_pos = 10'h3FF;
`else
        exp_inc = 10'h000; exp_neg = 10'h3FD; exp_pos = 10'h010;
`endif
        do_load(10'h3FF);
        INCREMENT = 1; step();
        tests++; if (OUT !== exp_inc) begin errors++; $display("FAIL inc_top: got %h expected %h", OUT, exp_inc); end
        do_load(10'd5);
        BRANCH = 1; OFFSET = 10'h3F8; step();
        tests++; if (OUT !== exp_neg) begin errors++; $display("FAIL branch_under: got %h expected %h", OUT, exp_neg); end
        do_load(10'h3F0);
        BRANCH = 1; OFFSET = 10'h020; step();
        tests++; if (OUT !== exp_pos) begin errors++; $display("FAIL branch_over: got %h expected %h", OUT, exp_pos); end
        do_load(10'd100);
        BRANCH = 1; INCREMENT = 1; OFFSET = 10'h3FD; step();
        tests++; if (OUT !== 10'd97) begin errors++; $display("FAIL branch_neg3: got %0d expected 97", OUT); end
    endtask

    task automatic test_stack_overflow();
        logic [BITS-1:0] exp_ret [4];
        exp_ret[0] = 10'd201; exp_ret[1] = 10'd201; exp_ret[2] = 10'd201; exp_ret[3] = 10'd101;
        do_load(10'd100);
        for (int i = 0; i < 4; i++) begin
            CALL = 1; DATA = 10'd200; step();
            tests++; if (OUT !== 10'd200 || STACK_DEPTH !== 3'(i + 1)) begin
                errors++; $display("FAIL call_%0d: got out=%0d depth=%0d expected out=200 depth=%0d", i, OUT, STACK_DEPTH, i + 1);
            end
        end
        tests++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", OVERFLOW); end
        CALL = 1; DATA = 10'd300; step();
        tests++; if (OUT !== 10'd200 || STACK_DEPTH !== 3'd4 || OVERFLOW !== 1'b1) begin
            errors++; $display("FAIL call_full: got out=%0d depth=%0d ovf=%b expected out=200 depth=4 ovf=1", OUT, STACK_DEPTH, OVERFLOW);
        end
        for (int i = 0; i < 4; i++) begin
            RETURN = 1; step();
            tests++; if (OUT !== exp_ret[i] || STACK_DEPTH !== 3'(3 - i)) begin
                errors++; $display("FAIL ret_%0d: got out=%0d depth=%0d expected out=%0d depth=%0d", i, OUT, STACK_DEPTH, exp_ret[i], 3 - i);
            end
        end
    endtask

    task automatic test_underflow();
        RETURN = 1; step();
        tests++; if (OUT !== 10'd101 || UNDERFLOW !== 1'b1 || STACK_DEPTH !== 3'd0) begin
            errors++; $display("FAIL ret_empty: got out=%0d unf=%b depth=%0d expected out=101 unf=1 depth=0", OUT, UNDERFLOW, STACK_DEPTH);
        end
        CLEAR_FLAGS = 1; RETURN = 1; step();
        tests++; if ({OVERFLOW, UNDERFLOW} !== 2'b01) begin errors++; $display("FAIL clear_vs_new: got %b expected 01", {OVERFLOW, UNDERFLOW}); end
        CLEAR_FLAGS = 1; step();
        tests++; if ({OVERFLOW, UNDERFLOW} !== 2'b00) begin errors++; $display("FAIL clear: got %b expected 00", {OVERFLOW, UNDERFLOW}); end
    endtask

    task automatic test_priority();
        do_load(10'd40);
        CALL = 1; RETURN = 1; LOAD = 1; DATA = 10'd7; step();
        tests++; if (OUT !== 10'd7 || STACK_DEPTH !== 3'd1) begin
            errors++; $display("FAIL call_prio: got out=%0d depth=%0d expected out=7 depth=1", OUT, STACK_DEPTH);
        end
        RETURN = 1; LOAD = 1; DATA = 10'd9; step();
        tests++; if (OUT !== 10'd41 || STACK_DEPTH !== 3'd0) begin
            errors++; $display("FAIL ret_prio: got out=%0d depth=%0d expected out=41 depth=0", OUT, STACK_DEPTH);
        end
        tests++; if ({OVERFLOW, UNDERFLOW} !== 2'b00) begin errors++; $display("FAIL prio_flags: got %b expected 00", {OVERFLOW, UNDERFLOW}); end
    endtask

    initial begin
        test_reset();
        test_load_inc();
        test_wrap();
        test_stack_overflow();
        test_underflow();
        test_priority();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
